// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution slice: func3 encodings,
// 2-bit predictor counter type and its saturating update rule.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t SNT = 2'b00;
   localparam bht_cnt_t WNT = 2'b01;
   localparam bht_cnt_t WT  = 2'b10;
   localparam bht_cnt_t ST  = 2'b11;

   function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
      bht_cnt_t nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != ST) nxt = cnt + 2'd1;
      end else begin
         if (cnt != SNT) nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational
// read port, one training write port, asynchronous reset to CNT_INIT.
module bht_2bit
   import branch_pkg::*;
#(
   parameter int unsigned BHT_DEPTH = 64,
   parameter bht_cnt_t    CNT_INIT  = WNT,
   localparam int unsigned IDX_W    = $clog2(BHT_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output bht_cnt_t         rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   bht_cnt_t cnt [BHT_DEPTH];

   // Read is the registered state, so a same-cycle write is not bypassed.
   assign rd_cnt = cnt[rd_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            cnt[i] <= CNT_INIT;
         end
      end else if (wr_en) begin
         cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX conditional branches one cycle later (redirect/flush) and
// predicts IF direction from a trained 2-bit BHT. Optional: BRU_PERF_CNT_EN.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned BHT_DEPTH = 64,
   parameter bht_cnt_t    CNT_INIT  = 2'b01
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   input  logic            ex_valid,
   input  logic            ex_kill,
   input  logic [2:0]      ex_func3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   output logic            res_valid,
   output logic            res_taken,
   output logic            res_mispredict,
   output logic [XLEN-1:0] res_redirect_pc,
   output logic            flush
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0]     perf_br_cnt,
   output logic [31:0]     perf_mis_cnt
`endif
);

   localparam int unsigned   IDX_W   = $clog2(BHT_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic            legal;
   logic            taken;
   logic            fire;
   logic [XLEN-1:0] target;
   bht_cnt_t        rd_cnt;
   logic            unused_bits;

   always_comb begin
      legal = 1'b1;
      taken = 1'b0;
      case (ex_func3)
         F3_BEQ:  taken = (ex_rs1 == ex_rs2);
         F3_BNE:  taken = (ex_rs1 != ex_rs2);
         F3_BLT:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
         F3_BGE:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
         F3_BLTU: taken = (ex_rs1 <  ex_rs2);
         F3_BGEU: taken = (ex_rs1 >= ex_rs2);
         default: legal = 1'b0;
      endcase
   end

   assign fire   = ex_valid & ~ex_kill & legal;
   assign target = taken ? (ex_pc + ex_imm) : (ex_pc + PC_STEP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid       <= 1'b0;
         res_taken       <= 1'b0;
         res_mispredict  <= 1'b0;
         res_redirect_pc <= '0;
      end else if (fire) begin
         res_valid       <= 1'b1;
         res_taken       <= taken;
         res_mispredict  <= taken ^ ex_pred_taken;
         res_redirect_pc <= target;
      end else begin
         res_valid       <= 1'b0;
         res_taken       <= 1'b0;
         res_mispredict  <= 1'b0;
      end
   end

   assign flush = res_mispredict;

   bht_2bit #(
      .BHT_DEPTH (BHT_DEPTH),
      .CNT_INIT  (CNT_INIT)
   ) u_bht (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (if_pc[IDX_W+1:2]),
      .rd_cnt   (rd_cnt),
      .wr_en    (fire),
      .wr_idx   (ex_pc[IDX_W+1:2]),
      .wr_taken (taken)
   );

   assign if_pred_taken = rd_cnt[1];

   // PC bits outside the index field and the counter LSB are intentionally unused.
   assign unused_bits = ^{if_pc, ex_pc, rd_cnt[0]};

`ifdef BRU_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_br_cnt  <= '0;
         perf_mis_cnt <= '0;
      end else if (fire) begin
         if (perf_br_cnt != '1) perf_br_cnt <= perf_br_cnt + 32'd1;
         if ((taken ^ ex_pred_taken) && (perf_mis_cnt != '1)) perf_mis_cnt <= perf_mis_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push expected
// resolutions; a negedge monitor pops and compares each res_valid strobe.
module tb_branch_resolve_unit;

   typedef struct {
      logic        taken;
      logic        mis;
      logic [31:0] pc;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        ex_valid;
   logic        ex_kill;
   logic [2:0]  ex_func3;
   logic [31:0] ex_rs1;
   logic [31:0] ex_rs2;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic        ex_pred_taken;
   logic        res_valid;
   logic        res_taken;
   logic        res_mispredict;
   logic [31:0] res_redirect_pc;
   logic        flush;
`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_br_cnt;
   logic [31:0] perf_mis_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   branch_resolve_unit #(
      .XLEN      (32),
      .BHT_DEPTH (64),
      .CNT_INIT  (2'b01)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .if_pc           (if_pc),
      .if_pred_taken   (if_pred_taken),
      .ex_valid        (ex_valid),
      .ex_kill         (ex_kill),
      .ex_func3        (ex_func3),
      .ex_rs1          (ex_rs1),
      .ex_rs2          (ex_rs2),
      .ex_pc           (ex_pc),
      .ex_imm          (ex_imm),
      .ex_pred_taken   (ex_pred_taken),
      .res_valid       (res_valid),
      .res_taken       (res_taken),
      .res_mispredict  (res_mispredict),
      .res_redirect_pc (res_redirect_pc),
      .flush           (flush)
`ifdef BRU_PERF_CNT_EN
      ,
      .perf_br_cnt     (perf_br_cnt),
      .perf_mis_cnt    (perf_mis_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                        input logic kill, input logic exp_fire, input logic exp_taken,
                        input logic [31:0] exp_pc);
      exp_t e;
      ex_valid      = 1'b1;
      ex_kill       = kill;
      ex_func3      = f3;
      ex_rs1        = rs1;
      ex_rs2        = rs2;
      ex_pc         = pc;
      ex_imm        = imm;
      ex_pred_taken = pred;
      if (exp_fire) begin
         e.taken = exp_taken;
         e.mis   = exp_taken ^ pred;
         e.pc    = exp_pc;
         e.cyc   = cyc + 1;
         sb.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                        input logic kill, input logic exp_fire, input logic exp_taken,
                        input logic [31:0] exp_pc);
      drive(f3, rs1, rs2, pc, imm, pred, kill, exp_fire, exp_taken, exp_pc);
      step();
   endtask

   task automatic idle();
      ex_valid = 1'b0;
      ex_kill  = 1'b0;
   endtask

   task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
      if_pc = pc;
      #1;
      check(name, if_pred_taken, exp);
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (res_valid) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_res_valid: got res_valid=1 at cycle %0d expected no strobe", cyc);
               end else begin
                  e = sb.pop_front();
                  check("res_cycle", cyc, e.cyc);
                  check("res_taken", res_taken, e.taken);
                  check("res_mispredict", res_mispredict, e.mis);
                  check("flush", flush, e.mis);
                  check("res_redirect_pc", res_redirect_pc, e.pc);
               end
            end else begin
               check("idle_flush", flush, 1'b0);
            end
         end
      end
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected $finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      if_pc = '0;
      idle();
      ex_func3 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_imm = '0; ex_pred_taken = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_res_valid", res_valid, 1'b0);
      check("reset_redirect", res_redirect_pc, 32'h0);
      check("reset_flush", flush, 1'b0);
      check_pred("reset_pred_40", 32'h40, 1'b0);
      rst = 1'b0;
      step();

      // Back-to-back: BLT signed overflow, BLTU, BGE
      drive(3'b100, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h200, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h204);
      step();
      drive(3'b110, 32'h1, 32'hFFFFFFFF, 32'h100, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF0);
      step();
      drive(3'b101, 32'h1, 32'hFFFFFFFF, 32'h100, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hF0);
      step();
      idle();
      step();

      // Training at 0x40 (counter 01)
      issue(3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h50); idle();
      check_pred("train_t1", 32'h40, 1'b1);
      issue(3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h50); idle();
      check_pred("train_t2", 32'h40, 1'b1);
      issue(3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h50); idle();
      check_pred("train_t3_sat", 32'h40, 1'b1);
      issue(3'b001, 32'd5, 32'd5, 32'h40, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44); idle();
      check_pred("train_n1", 32'h40, 1'b1);
      issue(3'b001, 32'd5, 32'd5, 32'h40, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44); idle();
      check_pred("train_n2", 32'h40, 1'b0);
      issue(3'b001, 32'd5, 32'd5, 32'h40, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44); idle();
      check_pred("train_n3", 32'h40, 1'b0);
      issue(3'b000, 32'd5, 32'd5, 32'h40, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h50); idle();
      check_pred("train_low_sat", 32'h40, 1'b0);

      // Same-cycle lookup and update (counter 01 -> 10)
      if_pc = 32'h40;
      drive(3'b000, 32'd7, 32'd7, 32'h40, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h50);
      #1;
      check("same_cycle_old", if_pred_taken, 1'b0);
      step();
      idle();
      check_pred("same_cycle_new", 32'h40, 1'b1);

      // Kill and illegal func3 leave counter 10 untouched
      issue(3'b001, 32'd5, 32'd5, 32'h40, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0); idle();
      check_pred("kill_no_train", 32'h40, 1'b1);
      issue(3'b010, 32'd5, 32'd5, 32'h40, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); idle();
      check_pred("illegal010_no_train", 32'h40, 1'b1);
      issue(3'b011, 32'd5, 32'd6, 32'h40, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); idle();
      check_pred("illegal011_no_train", 32'h40, 1'b1);
      issue(3'b001, 32'd5, 32'd5, 32'h40, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44); idle();
      check_pred("legal_after_kill", 32'h40, 1'b0);

      // PC wrap and remaining compares, back-to-back
      drive(3'b001, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h8, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4); step();
      drive(3'b000, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); step();
      drive(3'b111, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h340); step();
      drive(3'b100, 32'hFFFFFFFF, 32'd1, 32'h300, 32'hFFFFFF00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200); step();
      drive(3'b110, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h304); step();
      drive(3'b101, 32'hFFFFFFFF, 32'd1, 32'h300, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h304); step();
      idle();

      // Train index 63 (0xFC) to strong taken before a mid-run reset
      issue(3'b000, 32'd3, 32'd3, 32'hFC, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100); idle();
      issue(3'b000, 32'd3, 32'd3, 32'hFC, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100); idle();
      check_pred("pre_reset_pred_fc", 32'hFC, 1'b1);
      step();

      // In-flight branch dropped by asynchronous reset
      issue(3'b001, 32'd1, 32'd2, 32'h4, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      idle();
      rst = 1'b1;
      #1;
      check("midreset_res_valid", res_valid, 1'b0);
      check("midreset_res_taken", res_taken, 1'b0);
      check("midreset_res_mis", res_mispredict, 1'b0);
      check("midreset_flush", flush, 1'b0);
      check("midreset_redirect", res_redirect_pc, 32'h0);
      check_pred("midreset_pred_0", 32'h0, 1'b0);
      check_pred("midreset_pred_4", 32'h4, 1'b0);
      check_pred("midreset_pred_fc", 32'hFC, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step();

      issue(3'b000, 32'd9, 32'd9, 32'h4, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h14); idle();
      check_pred("post_reset_train", 32'h4, 1'b1);

      repeat (3) step();
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
